// File: rtl/spi_slave_sync_pkg.sv
// Shared definitions for the SPI slave: the FSM state encoding, the SPI mode
// encoding {CPOL,CPHA}, and small helpers that decode a latched mode.
package spi_slave_sync_pkg;

  // Frame sequencer states. The value is also exported on DBG_STATE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // SPI modes, encoded as {CPOL, CPHA}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  function automatic logic mode_cpol(spi_mode_t m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(spi_mode_t m);
    return m[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a change detector for one asynchronous input.
//
// Ports:
//   CLK       system clock
//   RST       synchronous active-high reset; chain is preset to RESET_VAL
//   async_sig asynchronous input pin
//   level     synchronized copy of async_sig (SYNC_STAGES cycles late)
//   toggle    1-cycle pulse whenever level differs from its previous value;
//             direction is recovered by the user from level itself
//             (rise = toggle & level, fall = toggle & ~level)
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_sig,
  output logic level,
  output logic toggle
);

  logic [SYNC_STAGES-1:0] pipe;
  logic                   prev;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe <= {SYNC_STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      pipe <= {pipe[SYNC_STAGES-2:0], async_sig};
      prev <= pipe[SYNC_STAGES-1];
    end
  end

  assign level  = pipe[SYNC_STAGES-1];
  assign toggle = level ^ prev;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running on the system clock. SCLK, SS_N and MOSI are
// oversampled through synchronizers; frames are WIDTH bits, LSB first, in any
// of the four CPOL/CPHA modes (mode latched at frame start).
//
// Ports:
//   CLK, RST           system clock, synchronous active-high reset
//   CPOL_IN, CPHA_IN   mode for the next frame
//   SCLK, SS_N, MOSI   asynchronous SPI inputs from the master
//   MISO, MISO_OE      serial data to the master and its output enable
//   TX_DATA, TX_LOAD   word for the next frame and its write strobe
//   TX_READY           TX buffer empty
//   RX_DATA, RX_VALID  last received word and its 1-cycle update pulse
//   BUSY               frame in progress (FSM not idle)
//   FRAME_ERR          1-cycle pulse: SS_N released mid-frame
//   UNDERRUN           1-cycle pulse: frame started with nothing to send
//   DBG_STATE          current FSM state
//
// TX handshake: TX_READY is the "ready" and TX_LOAD the "valid" of a
// one-entry buffer. A word transfers on a clock edge where both are 1;
// TX_LOAD while TX_READY=0 is dropped, never overwriting the stored word.
// RX_VALID has no back-pressure: RX_DATA is valid in the RX_VALID cycle and
// holds until the next completed frame.
module spi_slave_sync
  import spi_slave_sync_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CPOL_IN,
  input  logic             CPHA_IN,
  input  logic             SCLK,
  input  logic             SS_N,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_LOAD,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             BUSY,
  output logic             FRAME_ERR,
  output logic             UNDERRUN,
  output state_t           DBG_STATE
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  // Synchronized inputs
  logic sclk_s, sclk_tog;
  logic ss_s, ss_tog;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_pipe;

  // SS_N chain presets high so a released reset never fakes a select.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .CLK       (CLK),
    .RST       (RST),
    .async_sig (SCLK),
    .level     (sclk_s),
    .toggle    (sclk_tog)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .CLK       (CLK),
    .RST       (RST),
    .async_sig (SS_N),
    .level     (ss_s),
    .toggle    (ss_tog)
  );

  // MOSI goes through the same depth as SCLK so the data bit lines up with
  // the edge that samples it.
  always_ff @(posedge CLK) begin
    if (RST) mosi_pipe <= '0;
    else     mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
  end
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];

  // State
  state_t           state_q, state_d;
  spi_mode_t        mode_q, mode_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic             tx_full_q, tx_full_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             underrun_q, underrun_d;
  logic             miso_q, miso_d;

  // Edge classification against the latched mode. A change of the synced
  // SCLK away from CPOL is a leading edge, back to CPOL a trailing edge.
  logic             ss_fall;
  logic             lead_edge, trail_edge;
  logic             sample_edge, out_edge;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] load_word;

  assign ss_fall     = ss_tog & ~ss_s;
  assign lead_edge   = sclk_tog & (sclk_s != mode_cpol(mode_q));
  assign trail_edge  = sclk_tog & (sclk_s == mode_cpol(mode_q));
  assign sample_edge = mode_cpha(mode_q) ? trail_edge : lead_edge;
  assign out_edge    = mode_cpha(mode_q) ? lead_edge  : trail_edge;
  assign shift_in    = {mosi_s, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    count_d     = count_q;
    shift_d     = shift_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    underrun_d  = 1'b0;
    miso_d      = miso_q;
    load_word   = '0;

    // TX buffer write; LOAD below may override when it consumes the word.
    if (TX_LOAD && !tx_full_q) begin
      tx_buf_d  = TX_DATA;
      tx_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        miso_d  = 1'b0;
        count_d = '0;
        if (ss_fall) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        mode_d  = spi_mode_t'({CPOL_IN, CPHA_IN});
        count_d = '0;
        if (tx_full_q) begin
          load_word = tx_buf_q;
        end else if (TX_LOAD) begin
          // Word arriving in the load cycle itself goes straight out and is
          // not kept in the buffer.
          load_word = TX_DATA;
        end else begin
          load_word  = '0;
          underrun_d = 1'b1;
        end
        tx_full_d = 1'b0;
        shift_d   = load_word;
        // CPHA=0 must have bit 0 on the wire before the first leading edge;
        // CPHA=1 presents it on that edge instead.
        miso_d    = CPHA_IN ? 1'b0 : load_word[0];
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (sample_edge && !ss_s && count_q == LAST_BIT) begin
          // Final bit: publish the word and start the next frame straight
          // away while still selected.
          shift_d    = shift_in;
          rx_data_d  = shift_in;
          rx_valid_d = 1'b1;
          count_d    = '0;
          state_d    = ST_LOAD;
        end else if (ss_s) begin
          frame_err_d = (count_q != '0);
          count_d     = '0;
          miso_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (sample_edge) begin
          shift_d = shift_in;
          count_d = count_q + CW'(1);
        end else if (out_edge) begin
          miso_d = shift_q[0];
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE0;
      count_q     <= '0;
      shift_q     <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  assign MISO      = miso_q;
  assign MISO_OE   = (state_q != ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign TX_READY  = ~tx_full_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign UNDERRUN  = underrun_q;
  assign DBG_STATE = state_q;

endmodule
